// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
//
// Keypad-side operand entry. Collects decoded key events into a decimal digit
// buffer, shows the entry live in display encoding (0x0-0x9 digit, 0xE minus,
// 0xF blank, nibble 0 = least-significant digit) and, on Enter, converts the
// buffer to a WIDTH-bit two's-complement operand one digit per cycle
// (acc = acc*10 + digit), then presents it with a one-cycle valid pulse.
//
// Ports:
//   clock          system clock, all state on the rising edge
//   resetn         asynchronous active-low reset
//   key_valid      one-cycle strobe qualifying key_code
//   key_code       0x0-0x9 digit, 0xB backspace, 0xC clear, 0xD enter,
//                  0xE sign toggle; 0xA/0xF ignored
//   busy           high while converting / delivering; keys are dropped
//   operand        converted operand, held until the next conversion
//   operand_valid  one-cycle pulse when operand is updated
//   display        8-nibble entry display word
//   digit_count    number of digits currently in the buffer
//
// Build option:
//   OPERAND_ENTRY_BACKSPACE_EN  when defined, key 0xB removes the last digit;
//                               otherwise 0xB is ignored.
// -----------------------------------------------------------------------------
module operand_entry #(
   parameter int unsigned MAX_DIGITS = 6,
   parameter int unsigned WIDTH      = 21
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   output logic             busy,
   output logic [WIDTH-1:0] operand,
   output logic             operand_valid,
   output logic [31:0]      display,
   output logic [2:0]       digit_count
);

   localparam int unsigned BW = 4 * MAX_DIGITS;

   typedef enum logic [1:0] {
      ST_ENTRY,
      ST_CONVERT,
      ST_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [BW-1:0]    buf_q, buf_d;
   logic [2:0]       count_q, count_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [2:0]       idx_q, idx_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic             valid_q, valid_d;

   logic             is_digit;
   logic [BW-1:0]    buf_shr;
   logic [3:0]       digit_sel;
   logic [2:0]       minus_pos;

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_ENTRY;
         buf_q     <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         idx_q     <= '0;
         operand_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         operand_q <= operand_d;
         valid_q   <= valid_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ENTRY: begin
            if (key_valid && key_code == 4'hD) begin
               state_d = (count_q == 3'd0) ? ST_DONE : ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            if (idx_q == 3'd0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_ENTRY;
         end
         default: begin
            state_d = ST_ENTRY;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM outputs
   // -------------------------------------------------------------------------
   always_comb begin
      busy = (state_q != ST_ENTRY);
   end

   // -------------------------------------------------------------------------
   // Datapath next-state
   // -------------------------------------------------------------------------
   assign is_digit = (key_code <= 4'h9);

   // Digit under conversion: idx counts down from the most-significant digit.
   assign buf_shr   = buf_q >> {idx_q, 2'b00};
   assign digit_sel = buf_shr[3:0];

   always_comb begin
      buf_d     = buf_q;
      count_d   = count_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      operand_d = operand_q;
      valid_d   = 1'b0;

      unique case (state_q)
         ST_ENTRY: begin
            if (key_valid) begin
               if (is_digit) begin
                  // A lone zero is replaced rather than shifted, so leading
                  // zeros never occupy buffer positions.
                  if (count_q == 3'd0 || (count_q == 3'd1 && buf_q == '0)) begin
                     buf_d      = '0;
                     buf_d[3:0] = key_code;
                     count_d    = 3'd1;
                  end else if (count_q < 3'(MAX_DIGITS)) begin
                     buf_d   = {buf_q[BW-5:0], key_code};
                     count_d = count_q + 3'd1;
                  end
               end else begin
                  case (key_code)
                     4'hE: neg_d = ~neg_q;
                     4'hC: begin
                        buf_d   = '0;
                        count_d = '0;
                        neg_d   = 1'b0;
                     end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
                     4'hB: begin
                        if (count_q != 3'd0) begin
                           buf_d   = {4'h0, buf_q[BW-1:4]};
                           count_d = count_q - 3'd1;
                        end
                     end
`endif
                     4'hD: begin
                        acc_d = '0;
                        idx_d = count_q - 3'd1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_CONVERT: begin
            acc_d = (acc_q << 3) + (acc_q << 1) + {{(WIDTH-4){1'b0}}, digit_sel};
            idx_d = idx_q - 3'd1;
         end
         ST_DONE: begin
            operand_d = neg_q ? (~acc_q + 1'b1) : acc_q;
            valid_d   = 1'b1;
            buf_d     = '0;
            count_d   = '0;
            neg_d     = 1'b0;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Display: digits, then optional minus, then blanks. An empty buffer shows
   // a single 0, so the minus sits one position higher in that case.
   // -------------------------------------------------------------------------
   assign minus_pos = (count_q == 3'd0) ? 3'd1 : count_q;

   logic [3:0] nib [8];

   for (genvar g = 0; g < 8; g++) begin : g_nib
      logic [3:0] digit_g;
      if (g < MAX_DIGITS) begin : g_dig
         assign digit_g = buf_q[4*g +: 4];
      end else begin : g_nodig
         assign digit_g = 4'hF;
      end
      assign nib[g] = (3'(g) < count_q)                  ? digit_g :
                      (count_q == 3'd0 && 3'(g) == 3'd0) ? 4'h0    :
                      (neg_q && 3'(g) == minus_pos)      ? 4'hE    :
                                                           4'hF;
   end

   assign display       = {nib[7], nib[6], nib[5], nib[4], nib[3], nib[2], nib[1], nib[0]};
   assign operand       = operand_q;
   assign operand_valid = valid_q;
   assign digit_count   = count_q;

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
Keypad-side operand entry block, the input-direction counterpart of the calculator's result formatter. It accepts decoded key events and builds a decimal digit buffer and a live 8-nibble display word in the same display encoding the formatter produces. On Enter it converts the buffer to a 21-bit two's-complement operand over several cycles (one digit per cycle, Horner's method) and hands the operand to the ALU with a one-cycle valid pulse.

Parameters:
MAX_DIGITS, 6, maximum decimal digits accepted (must be ≤7 and fit 21-bit signed; 6 gives ±999999)
WIDTH, 21, operand width in bits; matches ALU operand/result width

Ports:
clock  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  0x0-0x9 digit, 0xB backspace, 0xC clear, 0xD enter, 0xE sign toggle; 0xA/0xF ignored
busy  output  1  high in CONVERT and DONE; keys ignored while high
operand  output  WIDTH  converted two's-complement operand, held until next conversion
operand_valid  output  1  one-cycle pulse when operand updated
display  output  32  entry shown in display encoding: nibble 0 = least-significant digit
digit_count  output  3  digits currently in buffer

Behaviour:
- Display encoding: 0x0-0x9 digit, 0xE minus, 0xF blank (0xA 'r' never produced here).
- Reset (async, resetn low): state ENTRY, buffer 0, digit_count 0, neg 0, operand 0, operand_valid 0, busy 0, display 32'hFFFFFFF0.
- States: ENTRY, CONVERT, DONE.
- ENTRY, digit key: if digit_count==0, or digit_count==1 and buffer==0 (leading-zero suppression), replace nibble 0 and set count to 1 (0 stays 0 with count 1). Else if count<MAX_DIGITS, buffer shifts left 4, new digit enters nibble 0, and count increments. Else the key is ignored.
- ENTRY, 0xE: toggle neg; buffer untouched.
- ENTRY, 0xC: buffer 0, count 0, neg 0.
- ENTRY, 0xB (feature-gated): if count>0, buffer shifts right 4 and count decrements; neg is kept.
- ENTRY, 0xD: acc←0, idx←count-1. If count==0, go to DONE; else go to CONVERT.
- CONVERT: each edge acc←acc*8+acc*2+buffer[idx], idx decrements. After the idx==0 digit, go to DONE. Occupies exactly digit_count cycles.
- DONE (one cycle): operand←neg ? -acc : acc (mod 2^WIDTH). -0 yields 0. Pulse operand_valid for exactly the following cycle. Clear buffer, count, and neg, then go to ENTRY.
- Latency: with Enter sampled at edge E0, operand_valid is high in the cycle after edge E(count+1). With count 0, that is the cycle after E1.
- Display, combinational from state: nibbles i<count = buffer digit i. If count==0, nibble 0 = 0x0. Next nibble above the digits = 0xE if neg. All higher nibbles = 0xF. Display is held unchanged during CONVERT.
- busy = state≠ENTRY. key_valid while busy is dropped, with no queuing.
- Reset mid-CONVERT: conversion is aborted, no operand_valid pulse, and operand returns to 0.

Optional Feature:
OPERAND_ENTRY_BACKSPACE_EN: when defined, 0xB performs backspace as above. When undefined, 0xB is ignored like 0xA/0xF and the backspace logic is absent.

Test Plan:
- Keys 1,2,3 → display 32'hFFFFF123, count 3. Then Enter → busy for 4 cycles; operand 21'h00007B, operand_valid pulses once, 4 edges after Enter; display returns to 32'hFFFFFFF0.
- Keys 4,5,0xE → display 32'hFFFFFE45. Then Enter → operand 21'h1FFFD3 (-45).
- Keys 9 ×7, then Enter → 7th digit ignored, count 6; operand 21'h0F423F (999999).
- Keys 0,0,5 → display 32'hFFFFFFF5, count 1. Enter alone from reset → operand 0, valid after 1 edge. 0xE then Enter → operand 0.
- Keys 1,2,0xB,3, Enter → operand 13 with the macro defined, 123 without it. A key pressed while busy is ignored.
- Keys 1,2,3, Enter, then resetn low 2 cycles after Enter → no operand_valid, operand 0, display 32'hFFFFFFF0, busy 0.
